// File: rtl/spi_pwm_pkg.sv
// Shared constants and helpers for the SPI-fed PWM register bank.
package spi_pwm_pkg;

   localparam int DATA_W = 8;

   typedef logic [DATA_W-1:0] byte_t;

   localparam byte_t ADDR_CTRL  = 8'h00;
   localparam byte_t ADDR_PRESC = 8'h01;
   localparam byte_t ADDR_DUTY0 = 8'h02;
   localparam byte_t ADDR_ID    = 8'h0F;

   localparam int    CTRL_CLR_BIT = 7;
   localparam byte_t CNT_MAX      = 8'hFF;

   // Address of the DUTY register that belongs to channel ch.
   function automatic byte_t duty_addr(input int ch);
      return ADDR_DUTY0 + DATA_W'(ch);
   endfunction

endpackage

// File: rtl/spi_wr_sync.sv
// Brings the SCLK-domain write strobe into clk and turns each rising edge into a 1-cycle pulse.
module spi_wr_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // NOTE: flops use non-blocking assignments so each stage samples its pre-edge neighbour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= async_in;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign pulse = r_sync & ~r_prev;

endmodule

// File: rtl/spi_pwm_regbank.sv
// Register bank written from the SPI slave plus NUM_CH shadowed PWM outputs.
module spi_pwm_regbank
   import spi_pwm_pkg::*;
#(
   parameter int    NUM_CH   = 4,
   parameter byte_t ID_VALUE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_wr_en,
   input  logic [7:0]        spi_addr,
   input  logic [7:0]        spi_data_wr,
   output logic [7:0]        spi_data_rd,
   output logic [NUM_CH-1:0] pwm_out
);

   logic              w_wr_pulse;
   logic              w_clr;
   logic              w_tick;
   logic              w_wrap;
   logic              w_pcnt_restart;
   byte_t             w_rd_mux;
   logic [NUM_CH-1:0] w_pwm_next;

   byte_t             r_ctrl;
   byte_t             r_presc;
   byte_t             r_duty     [NUM_CH];
   byte_t             r_duty_act [NUM_CH];
   byte_t             r_pcnt;
   byte_t             r_cnt;
   byte_t             r_rd;
   logic [NUM_CH-1:0] r_pwm;

   spi_wr_sync u_wr_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (spi_wr_en),
      .pulse    (w_wr_pulse)
   );

   // Address and data are quasi-static while the strobe is high, so they are sampled directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctrl  <= '0;
         r_presc <= '0;
         // NOTE: the DUTY array is small and its reset value is observable, so it is reset like any register.
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r_duty[ch] <= '0;
         end
      end else if (w_wr_pulse) begin
         if (spi_addr == ADDR_CTRL) begin
            r_ctrl <= spi_data_wr;
         end
         if (spi_addr == ADDR_PRESC) begin
            r_presc <= spi_data_wr;
         end
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (spi_addr == duty_addr(ch)) begin
               r_duty[ch] <= spi_data_wr;
            end
         end
      end
   end

   always_comb begin
      // NOTE: the default comes first so every path assigns w_rd_mux and no latch is inferred.
      w_rd_mux = '0;
      if (spi_addr == ADDR_CTRL) begin
         w_rd_mux = r_ctrl;
      end
      if (spi_addr == ADDR_PRESC) begin
         w_rd_mux = r_presc;
      end
      if (spi_addr == ADDR_ID) begin
         w_rd_mux = ID_VALUE;
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (spi_addr == duty_addr(ch)) begin
            w_rd_mux = r_duty[ch];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd <= '0;
      end else begin
         r_rd <= w_rd_mux;
      end
   end

   assign w_clr  = r_ctrl[CTRL_CLR_BIT];
   assign w_tick = !w_clr && (r_pcnt == r_presc);
   assign w_wrap = w_tick && (r_cnt == CNT_MAX);
   // A PRESC lowered below the running count restarts the prescaler instead of running out to 255.
   assign w_pcnt_restart = w_clr || (r_pcnt >= r_presc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcnt <= '0;
      end else if (w_pcnt_restart) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_clr) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Active duty only changes at a period boundary or while cleared, so no runt pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r_duty_act[ch] <= '0;
         end
      end else if (w_clr || w_wrap) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r_duty_act[ch] <= r_duty[ch];
         end
      end
   end

   always_comb begin
      w_pwm_next = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         w_pwm_next[ch] = r_ctrl[ch] && !w_clr && (r_cnt < r_duty_act[ch]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwm <= '0;
      end else begin
         r_pwm <= w_pwm_next;
      end
   end

   assign spi_data_rd = r_rd;
   assign pwm_out     = r_pwm;

endmodule

// File: tb/tb_spi_pwm_regbank.sv
// Self-checking bench: cycle model of the register bank and PWM rules, compared every clock.
module tb_spi_pwm_regbank;

   localparam int NUM_CH = 4;
   localparam int ID_VAL = 'hA5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              spi_wr_en = 1'b0;
   logic [7:0]        spi_addr = 8'h00;
   logic [7:0]        spi_data_wr = 8'h00;
   logic [7:0]        spi_data_rd;
   logic [NUM_CH-1:0] pwm_out;

   int n_chk = 0;
   int n_err = 0;

   // Behavioural model state (plain integers).
   int m_ctrl, m_presc, m_pcnt, m_cnt;
   int m_duty [NUM_CH];
   int m_act  [NUM_CH];
   int m_s1, m_s2, m_s3;
   int exp_rd, exp_pwm;
   int hi_cnt [NUM_CH];

   spi_pwm_regbank #(
      .NUM_CH   (NUM_CH),
      .ID_VALUE (8'hA5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .spi_wr_en   (spi_wr_en),
      .spi_addr    (spi_addr),
      .spi_data_wr (spi_data_wr),
      .spi_data_rd (spi_data_rd),
      .pwm_out     (pwm_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
         end
      end
   endtask

   function automatic int m_read(input int a);
      if (a == 0) return m_ctrl;
      if (a == 1) return m_presc;
      if (a >= 2 && a < 2 + NUM_CH) return m_duty[a-2];
      if (a == 15) return ID_VAL;
      return 0;
   endfunction

   task automatic model_reset();
      m_ctrl = 0; m_presc = 0; m_pcnt = 0; m_cnt = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_duty[ch] = 0;
         m_act[ch]  = 0;
      end
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      exp_rd = 0; exp_pwm = 0;
   endtask

   // One clock edge of the specification's rules, evaluated on pre-edge state.
   task automatic model_step();
      int clr, tick, wrap, a;
      if (rst) begin
         model_reset();
      end else begin
         clr  = (m_ctrl >> 7) & 1;
         tick = (clr == 0 && m_pcnt == m_presc) ? 1 : 0;
         wrap = (tick == 1 && m_cnt == 255) ? 1 : 0;
         exp_rd = m_read(int'(spi_addr));
         exp_pwm = 0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (((m_ctrl >> ch) & 1) == 1 && clr == 0 && m_cnt < m_act[ch]) exp_pwm |= (1 << ch);
         end
         if (clr == 1 || wrap == 1) begin
            for (int ch = 0; ch < NUM_CH; ch++) m_act[ch] = m_duty[ch];
         end
         m_pcnt = (clr == 1 || m_pcnt >= m_presc) ? 0 : m_pcnt + 1;
         if (clr == 1) m_cnt = 0;
         else if (tick == 1) m_cnt = (m_cnt + 1) % 256;
         // Write commits on the edge two samples after the strobe was first seen high.
         if (m_s2 == 1 && m_s3 == 0) begin
            a = int'(spi_addr);
            if (a == 0) m_ctrl = int'(spi_data_wr);
            else if (a == 1) m_presc = int'(spi_data_wr);
            else if (a >= 2 && a < 2 + NUM_CH) m_duty[a-2] = int'(spi_data_wr);
         end
         m_s3 = m_s2;
         m_s2 = m_s1;
         m_s1 = int'(spi_wr_en);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(posedge clk);
      #1;
      check("rd_data", 32'(spi_data_rd), 32'(exp_rd));
      check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
   end

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic spi_write(input logic [7:0] a, input logic [7:0] d, input int hold);
      @(negedge clk);
      spi_addr    = a;
      spi_data_wr = d;
      spi_wr_en   = 1'b1;
      repeat (hold) @(negedge clk);
      spi_wr_en = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic read_check(input logic [7:0] a, input int exp, input string name);
      @(negedge clk);
      spi_addr = a;
      @(negedge clk);
      check(name, 32'(spi_data_rd), 32'(exp));
   endtask

   task automatic count_win(input int n);
      for (int ch = 0; ch < NUM_CH; ch++) hi_cnt[ch] = 0;
      repeat (n) begin
         @(negedge clk);
         for (int ch = 0; ch < NUM_CH; ch++) hi_cnt[ch] += int'(pwm_out[ch]);
      end
   endtask

   function automatic logic [7:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0, 1:    return 8'h00;
         2:       return 8'h01;
         3:       return 8'h02;
         4:       return 8'h03;
         5:       return 8'h04;
         6:       return 8'h05;
         7:       return 8'h0F;
         default: return 8'($urandom_range(0, 127));
      endcase
   endfunction

   initial begin
      int guard;
      logic [7:0] a, d;

      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state and read path.
      read_check(8'h0F, 'hA5, "rd_id");
      read_check(8'h00, 'h00, "rd_ctrl_reset");
      read_check(8'h05, 'h00, "rd_duty3_reset");
      check("pwm_reset", 32'(pwm_out), 32'h0);

      // Long strobe: one write only; a data change after the commit must not be picked up.
      @(negedge clk);
      spi_addr = 8'h02; spi_data_wr = 8'h40; spi_wr_en = 1'b1;
      repeat (10) @(negedge clk);
      spi_data_wr = 8'h7F;
      repeat (10) @(negedge clk);
      spi_wr_en = 1'b0;
      repeat (4) @(negedge clk);
      read_check(8'h02, 'h40, "duty0_single_write");

      // Channel 0 at 64/256.
      spi_write(8'h00, 8'h01, 5);
      spi_write(8'h01, 8'h00, 5);
      repeat (600) @(negedge clk);
      count_win(256);
      check("ch0_high_64", hi_cnt[0], 64);
      check("ch1_idle", hi_cnt[1], 0);
      check("ch3_idle", hi_cnt[3], 0);

      // Mid-period duty change at cnt=0x80.
      guard = 0;
      while (m_cnt != 'h7C && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("wait_cnt_7c", 32'(guard < 2000), 32'h1);
      spi_write(8'h02, 8'hC0, 4);
      repeat (600) @(negedge clk);
      count_win(256);
      check("ch0_high_192", hi_cnt[0], 192);

      // Corner duties on channel 1.
      spi_write(8'h00, 8'h03, 5);
      spi_write(8'h03, 8'h00, 5);
      repeat (600) @(negedge clk);
      count_win(256);
      check("ch1_duty00", hi_cnt[1], 0);
      spi_write(8'h03, 8'hFF, 5);
      repeat (600) @(negedge clk);
      count_win(256);
      check("ch1_dutyff", hi_cnt[1], 255);

      // PRESC=3 stretches the period to 1024 clk.
      spi_write(8'h01, 8'h03, 5);
      repeat (2200) @(negedge clk);
      count_win(1024);
      check("presc3_ch0", hi_cnt[0], 768);
      check("presc3_ch1", hi_cnt[1], 1020);

      // Counter clear mid-period, then restart from cnt=0.
      repeat (300) @(negedge clk);
      spi_write(8'h00, 8'h83, 4);
      check("clr_pwm_low", 32'(pwm_out), 32'h0);
      count_win(40);
      check("clr_ch0_held", hi_cnt[0], 0);
      spi_write(8'h00, 8'h03, 4);
      check("restart_ch0_high", 32'(pwm_out[0]), 32'h1);
      check("restart_ch1_high", 32'(pwm_out[1]), 32'h1);
      repeat (1200) @(negedge clk);
      spi_write(8'h01, 8'h00, 5);

      // Reset while a write is in the synchronizer: nothing lands.
      @(negedge clk);
      spi_addr = 8'h01; spi_data_wr = 8'h55; spi_wr_en = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      spi_wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      read_check(8'h01, 'h00, "presc_after_rst_write");
      check("pwm_after_rst", 32'(pwm_out), 32'h0);

      // Randomized traffic; the per-cycle compare does the checking.
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(4, 12)) begin
            @(negedge clk);
            spi_addr = rand_addr();
         end
         a = rand_addr();
         d = 8'($urandom_range(0, 255));
         if (a == 8'h00) d = (d & 8'h7F) | (($urandom_range(0, 7) == 0) ? 8'h80 : 8'h00);
         if (a == 8'h01) d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
         spi_write(a, d, $urandom_range(4, 10));
      end
      repeat (20) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
